if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline; the producer end of the IF→ID interface. It holds the architectural PC, fetches 32-bit instructions over the byte-wide memory arbiter port through a small direct-mapped instruction cache, and presents `pc_o`/`inst_o` with `if_id_rdy` to the decode stage. It honours the decode-stage stall (`id_stall`) and the EX-stage branch/jump redirect.

---
 rtl/if_fetch_pkg.sv | 18 +
 rtl/if_fetch_icache.sv | 47 ++++
 rtl/if_fetch.sv | 145 ++++++++++++++
 tb/tb_if_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, cache geometry
// and the fetch FSM state encoding.
package if_fetch_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;
  localparam logic [AddrLen-1:0] ZERO_WORD = '0;

  localparam int ICacheLines  = 64;
  localparam int ICacheIdxLen = $clog2(ICacheLines);
  localparam int ICacheTagLen = AddrLen - ICacheIdxLen - 2;

  typedef enum logic {
    IF_IDLE  = 1'b0,
    IF_FETCH = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: flop arrays for valid,
// tag and data, combinational lookup, synchronous single write port.
module icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = ICacheLines,
  parameter int IDX_W = ICacheIdxLen,
  parameter int TAG_W = ICacheTagLen
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [InstLen-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [InstLen-1:0] wr_data
);

  logic               valid [LINES];
  logic [TAG_W-1:0]   tags  [LINES];
  logic [InstLen-1:0] words [LINES];

  // Line storage: cleared on reset, one line written per completed fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        valid[i] <= 1'b0;
        tags[i]  <= '0;
        words[i] <= '0;
      end
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  // Lookup is purely combinational so a hit can be presented the next cycle.
  always_comb begin
    hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    rd_data = words[rd_idx];
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: holds the PC, looks up the instruction cache and on
// a miss assembles the word from four byte reads through the memory arbiter.
// Presents pc_o/inst_o with if_id_rdy to decode; EX redirects take priority.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = ICacheLines
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               branch_en,
  input  logic [AddrLen-1:0] branch_target,
  input  logic               id_stall,
  output logic               mem_req,
  output logic [AddrLen-1:0] mem_addr,
  input  logic               mem_gnt,
  input  logic [7:0]         mem_data,
  output logic [AddrLen-1:0] pc_o,
  output logic [InstLen-1:0] inst_o,
  output logic               if_id_rdy
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = AddrLen - IDX_W - 2;

  if_state_e          state;
  logic [AddrLen-1:0] pc;
  logic [2:0]         issue_cnt;
  logic [1:0]         recv_cnt;
  logic               pend;
  logic [23:0]        asm_bytes;

  logic               hit;
  logic [InstLen-1:0] line;
  logic               slot_free;
  logic               issuing;
  logic               granted;
  logic               fetch_done;
  logic               cache_we;
  logic [InstLen-1:0] fetch_word;

  icache #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[IDX_W+1:2]),
    .rd_tag  (pc[AddrLen-1:IDX_W+2]),
    .hit     (hit),
    .rd_data (line),
    .wr_en   (cache_we),
    .wr_idx  (pc[IDX_W+1:2]),
    .wr_tag  (pc[AddrLen-1:IDX_W+2]),
    .wr_data (fetch_word)
  );

  // Request, handshake and completion decode for the current cycle.
  always_comb begin
    slot_free  = !if_id_rdy || !id_stall;
    issuing    = (state == IF_FETCH) && !issue_cnt[2];
    mem_req    = rdy && issuing;
    mem_addr   = mem_req ? (pc + {29'b0, issue_cnt}) : ZERO_WORD;
    granted    = mem_req && mem_gnt;
    fetch_done = (state == IF_FETCH) && pend && (recv_cnt == 2'd3);
    fetch_word = {mem_data, asm_bytes};
    cache_we   = rdy && !branch_en && fetch_done;
  end

  // Fetch FSM with PC, counters and the registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IF_IDLE;
      pc        <= ZERO_WORD;
      pc_o      <= ZERO_WORD;
      inst_o    <= '0;
      if_id_rdy <= 1'b0;
      issue_cnt <= 3'd0;
      recv_cnt  <= 2'd0;
      pend      <= 1'b0;
    end else if (rdy) begin
      if (branch_en) begin
        // Redirect abandons any fetch; an in-flight byte is dropped via pend.
        pc        <= branch_target & ~32'h3;
        if_id_rdy <= 1'b0;
        state     <= IF_IDLE;
        issue_cnt <= 3'd0;
        recv_cnt  <= 2'd0;
        pend      <= 1'b0;
      end else begin
        case (state)
          IF_IDLE: begin
            pend <= 1'b0;
            if (slot_free) begin
              if (hit) begin
                pc_o      <= pc;
                inst_o    <= line;
                if_id_rdy <= 1'b1;
                pc        <= pc + 32'd4;
              end else begin
                if_id_rdy <= 1'b0;
                issue_cnt <= 3'd0;
                recv_cnt  <= 2'd0;
                state     <= IF_FETCH;
              end
            end
          end
          IF_FETCH: begin
            pend <= granted;
            if (granted) begin
              issue_cnt <= issue_cnt + 3'd1;
            end
            if (pend) begin
              if (fetch_done) begin
                pc_o      <= pc;
                inst_o    <= fetch_word;
                if_id_rdy <= 1'b1;
                pc        <= pc + 32'd4;
                state     <= IF_IDLE;
              end else begin
                recv_cnt <= recv_cnt + 2'd1;
              end
            end
          end
          default: state <= IF_IDLE;
        endcase
      end
    end
  end

  // Little-endian assembly of the first three bytes; byte 3 goes straight out.
  always_ff @(posedge clk) begin
    if (rdy && !branch_en && (state == IF_FETCH) && pend) begin
      case (recv_cnt)
        2'd0:    asm_bytes[7:0]   <= mem_data;
        2'd1:    asm_bytes[15:8]  <= mem_data;
        2'd2:    asm_bytes[23:16] <= mem_data;
        default: asm_bytes        <= asm_bytes;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle tables plus randomized run checked
// against an instruction-stream reference model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, branch_en, id_stall, mem_gnt;
  logic [31:0] branch_target;
  logic        mem_req, if_id_rdy;
  logic [31:0] mem_addr, pc_o, inst_o;
  logic [7:0]  mem_data = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  logic        granted;
  logic [31:0] gaddr;

  typedef struct {
    logic        r, g, s, b;
    logic [31:0] t;
    logic        req;
    logic [31:0] addr;
    logic        ordy;
    logic [31:0] pc;
  } row_t;

  row_t tbl[$];

  if_fetch #(.ICACHE_LINES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .id_stall      (id_stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_data      (mem_data),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .if_id_rdy     (if_id_rdy)
  );

  always #5 clk = ~clk;

  // Program memory image: word 0 is fixed, everything else is a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h00500093;
    return (w * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[a[1:0]*8 +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, g, s, b, input logic [31:0] t);
    rdy = r; mem_gnt = g; id_stall = s; branch_en = b; branch_target = t;
    #1;
  endtask

  // Advance one clock; the arbiter returns the granted byte the next cycle.
  task automatic cyc();
    granted = !rst && rdy && mem_req && mem_gnt;
    gaddr   = mem_addr;
    @(posedge clk);
    #1;
    if (granted) mem_data = mem_byte(gaddr);
  endtask

  task automatic apply_row(input row_t rw, input string tag);
    drive(rw.r, rw.g, rw.s, rw.b, rw.t);
    chk({tag, " mem_req"},   {31'b0, mem_req},   {31'b0, rw.req});
    chk({tag, " mem_addr"},  mem_addr,           rw.addr);
    chk({tag, " if_id_rdy"}, {31'b0, if_id_rdy}, {31'b0, rw.ordy});
    if (rw.ordy) begin
      chk({tag, " pc_o"},   pc_o,   rw.pc);
      chk({tag, " inst_o"}, inst_o, mem_word(rw.pc));
    end
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int          consumed;
    logic [31:0] exp_pc, prev_pc, prev_inst, t;
    logic        r, g, s, b, hold_prev;

    // ---------------- reset state ----------------
    do_reset();
    rst = 1'b1;
    drive(1, 1, 0, 0, 32'h0);
    chk("reset if_id_rdy", {31'b0, if_id_rdy}, 32'h0);
    chk("reset pc_o",      pc_o,               32'h0);
    chk("reset inst_o",    inst_o,             32'h0);
    chk("reset mem_req",   {31'b0, mem_req},   32'h0);
    chk("reset mem_addr",  mem_addr,           32'h0);
    cyc();
    rst = 1'b0;

    // ---------------- directed table: miss, stall, redirect hit, grant gaps
    //            r  g  s  b  target  req addr  ordy pc
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0});   // L: lookup 0 misses
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h1, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h2, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h3, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0});   // L+6: word 0 ready
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h4, 0, 32'h0});   // next fetch at 4
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h5, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h6, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h7, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h4});   // stall x3
    tbl.push_back('{1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h4});
    tbl.push_back('{1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h4});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4});   // consumed once
    tbl.push_back('{1, 1, 0, 1, 32'h0, 1, 32'h8, 0, 32'h0});   // redirect to 0
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0});   // lookup 0 hits
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4});   // 4 hits too
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h8, 0, 32'h0});   // 8 misses
    tbl.push_back('{1, 0, 0, 0, 32'h0, 1, 32'h9, 0, 32'h0});   // no grant x2
    tbl.push_back('{1, 0, 0, 0, 32'h0, 1, 32'h9, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'h9, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'hA, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 1, 32'hB, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h8});
    foreach (tbl[i]) apply_row(tbl[i], $sformatf("tbl[%0d]", i));

    // ---------------- redirect in the middle of a fetch ----------------
    apply_row('{1, 1, 0, 0, 32'h0,        0, 32'h0,    1, 32'h8},    "br0");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'hC,    0, 32'h0},    "br1");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'hD,    0, 32'h0},    "br2");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'hE,    0, 32'h0},    "br3");
    apply_row('{1, 1, 0, 1, 32'h00001003, 1, 32'hF,    0, 32'h0},    "br4");
    apply_row('{1, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0},    "br5");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'h1000, 0, 32'h0},    "br6");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'h1001, 0, 32'h0},    "br7");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'h1002, 0, 32'h0},    "br8");
    apply_row('{1, 1, 0, 0, 32'h0,        1, 32'h1003, 0, 32'h0},    "br9");
    apply_row('{1, 1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0},    "br10");
    apply_row('{1, 1, 1, 0, 32'h0,        0, 32'h0,    1, 32'h1000}, "br11");
    apply_row('{1, 1, 1, 1, 32'h0000000C, 0, 32'h0,    1, 32'h1000}, "br12");

    // ---------------- rdy low during a miss (also: 0xC was never cached) --
    apply_row('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0}, "rdy0");
    apply_row('{1, 1, 0, 0, 32'h0, 1, 32'hC, 0, 32'h0}, "rdy1");
    apply_row('{1, 1, 0, 0, 32'h0, 1, 32'hD, 0, 32'h0}, "rdy2");
    apply_row('{0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0}, "rdy3");
    apply_row('{0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0}, "rdy4");
    apply_row('{0, 1, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0}, "rdy5");
    apply_row('{0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0}, "rdy6");
    apply_row('{1, 1, 0, 0, 32'h0, 1, 32'hE, 0, 32'h0}, "rdy7");
    apply_row('{1, 1, 0, 0, 32'h0, 1, 32'hF, 0, 32'h0}, "rdy8");
    apply_row('{1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0}, "rdy9");
    apply_row('{1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 32'hC}, "rdy10");

    // ---------------- randomized run against the instruction-stream model --
    do_reset();
    exp_pc    = 32'h0;
    hold_prev = 1'b0;
    prev_pc   = 32'h0;
    prev_inst = 32'h0;
    consumed  = 0;
    for (int cyc_i = 0; cyc_i < 4000; cyc_i++) begin
      r = ($urandom % 8) != 0;
      g = ($urandom % 4) != 0;
      s = ($urandom % 4) == 0;
      b = ($urandom % 40) == 0;
      case ($urandom % 4)
        0:       t = 32'hFFFFFFF0 | ($urandom % 16);
        1:       t = $urandom % 1024;
        default: t = $urandom % 512;
      endcase
      drive(r, g, s, b, t);

      if (!r) chk("rnd req while frozen", {31'b0, mem_req}, 32'h0);
      if (mem_req) chk("rnd fetch addr window", {31'b0, (mem_addr - exp_pc) < 32'd4}, 32'h1);
      if (hold_prev) begin
        chk("rnd hold if_id_rdy", {31'b0, if_id_rdy}, 32'h1);
        chk("rnd hold pc_o",      pc_o,               prev_pc);
        chk("rnd hold inst_o",    inst_o,             prev_inst);
      end
      if (r && if_id_rdy && !s) begin
        chk("rnd stream pc",   pc_o,   exp_pc);
        chk("rnd stream inst", inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (r && b) exp_pc = t & ~32'h3;
      hold_prev = if_id_rdy && (!r || (s && !b));
      prev_pc   = pc_o;
      prev_inst = inst_o;
      cyc();
    end
    chk("rnd progress", {31'b0, consumed >= 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
